fpr_wb: RTL and testbench
=========================

Name: fpr_wb

Overview:
- Floating-point write-back stage that drives the FBUS slave write port of the RV32F register file.
- Merges two result sources into the single write port:
  - single-cycle in-order results from the pipeline (FP loads, FMV.W.X, FADD/FMUL, etc.);
  - long-latency results from the iterative FDIV/FSQRT unit.
- Long-latency results are buffered in a small FIFO.
- Keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards against in-flight long-latency ops.

Parameters:
- MAX_FPR, 32, number of FP registers (from cpu_params_pkg).
- FLEN, 32, FP register width (from cpu_params_pkg).
- QDEPTH, 4, long-latency result FIFO depth; power of 2, minimum 2.

Ports:
- clk_in  input  1  system clock
- reset_in  input  1  synchronous active-high reset
- pipe_wr  input  1  pipeline result valid this cycle; always accepted
- pipe_Fd_addr  input  log2(MAX_FPR)  pipeline destination register
- pipe_Fd_data  input  FLEN  pipeline result
- lat_issue  input  1  decode issued a long-latency op this cycle
- lat_issue_Fd  input  log2(MAX_FPR)  destination of that op
- lat_valid  input  1  long-latency unit result valid
- lat_ready  output  1  FIFO can accept; equals !full
- lat_Fd_addr  input  log2(MAX_FPR)  long-latency destination register
- lat_Fd_data  input  FLEN  long-latency result
- lat_fflags  input  5  exception flags for the long-latency result
- pipe_fflags  input  5  exception flags for the pipeline result
- fpr_pend  output  MAX_FPR  scoreboard; bit k = long-latency write to Fk outstanding
- fpr_bus  FBUS_intf.master  -  drives Fd_wr, Fd_addr, Fd_data

Behaviour:
- Single clock clk_in; reset_in is synchronous and active-high.
- Reset values:
  - Fd_wr, Fd_addr and Fd_data = 0;
  - FIFO empty, so lat_ready = 1;
  - fpr_pend = 0.
- Write port is registered: a source accepted in cycle N produces Fd_wr = 1 in cycle N+1, so the register file updates at the end of N+1.
- Per-cycle arbitration, pipeline has absolute priority:
  - pipe_wr = 1: write the pipeline result; the FIFO head waits.
  - pipe_wr = 0 and FIFO not empty: pop the head and write it.
  - Otherwise Fd_wr = 0. Fd_addr/Fd_data hold their last value.
- FIFO handshake:
  - Push when lat_valid & lat_ready.
  - Entry = {addr, data, fflags}.
  - Push and pop in the same cycle are both allowed when not full; a push while full is impossible because lat_ready = 0.
  - When the FIFO is empty, a push is visible as the head no earlier than the next cycle (no flow-through).
- Pointers:
  - log2(QDEPTH)+1 bits each; the MSB distinguishes full from empty.
  - Pointers wrap modulo 2*QDEPTH.
  - count = wr_ptr - rd_ptr.
- Scoreboard:
  - lat_issue sets fpr_pend[lat_issue_Fd].
  - A FIFO pop clears fpr_pend[popped addr].
  - Set and clear of the same bit in the same cycle: set wins.
  - Issue to an already-pending register is illegal; decode stalls on fpr_pend. Covered by an assertion.
- The ordering hazard (pipe write and a queued long-latency write to the same Fd) cannot occur because decode stalls on fpr_pend.
- Starvation: a continuous stream of pipe_wr holds the FIFO, so lat_ready drops. This is acceptable and bounded by the pipeline.
- Reset mid-operation: FIFO contents are discarded, the scoreboard is cleared, and no write is issued in the cycle after reset.

Optional Feature:
- Macro: FPR_WB_FFLAGS_EN.
- Enabled, adds:
  - output fflags_acc[4:0], a sticky OR of pipe_fflags (on pipe_wr) and the popped entry's fflags (on pop), updated in the same cycle as the write;
  - input fflags_clr, which clears fflags_acc; if a clear and a new flag arrive in the same cycle, the new flags are retained.
- Disabled:
  - fflags ports and FIFO flag bits are removed;
  - FIFO width is addr + FLEN only.

Decomposition:
- cpu_params_pkg holds MAX_FPR and FLEN.
- Add to cpu_params_pkg:
  - FPR_AW = $clog2(MAX_FPR);
  - typedef fpr_wb_ent_t {addr, data, fflags}.
- One sub-module: fpr_wb_fifo, a parameterised synchronous FIFO (push/pop/full/empty/head) instantiated once.

Test Plan:
- Reset, then pipe_wr with addr 3, data 0x3F800000 → next cycle Fd_wr = 1, Fd_addr = 3, Fd_data = 0x3F800000; lat_ready = 1; fpr_pend = 0.
- lat_issue Fd = 5; three cycles later lat_valid with addr 5, data 0x40490FDB, while pipe_wr = 0 → written 2 cycles after the push; fpr_pend[5] goes 1 → 0 in the pop cycle.
- Push 4 FIFO entries while pipe_wr = 1 every cycle → lat_ready = 0 after the 4th push. Release pipe_wr → 4 consecutive writes in FIFO order, and lat_ready returns to 1 one cycle after the first pop.
- Same cycle: lat_issue Fd = 7 and a pop of an entry for Fd = 7 → fpr_pend[7] stays 1.
- Fill the FIFO to 3 entries, then assert reset_in for 1 cycle → no Fd_wr afterwards, empty, fpr_pend = 0.
- With FPR_WB_FFLAGS_EN: pipe_fflags = 0x01, then a popped entry with fflags 0x08 → fflags_acc = 0x09; fflags_clr with a simultaneous 0x02 → fflags_acc = 0x02.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// CPU-wide parameters plus the FP write-back FIFO entry type.
// Build option: FPR_WB_FFLAGS_EN adds exception flags to each FIFO entry.
package cpu_params_pkg;

    localparam int unsigned MAX_FPR = 32;
    localparam int unsigned FLEN    = 32;
    localparam int unsigned FPR_AW  = $clog2(MAX_FPR);

    typedef struct packed {
        logic [FPR_AW-1:0] addr;
        logic [FLEN-1:0]   data;
`ifdef FPR_WB_FFLAGS_EN
        logic [4:0]        fflags;
`endif
    } fpr_wb_ent_t;

endpackage

// File: rtl/fpr_wb_if.sv
// FBUS write port into the FP register file.
interface FBUS_intf;
    import cpu_params_pkg::*;

    logic              Fd_wr;
    logic [FPR_AW-1:0] Fd_addr;
    logic [FLEN-1:0]   Fd_data;

    modport master (output Fd_wr, output Fd_addr, output Fd_data);
    modport slave  (input  Fd_wr, input  Fd_addr, input  Fd_data);
endinterface

// File: rtl/fpr_wb_fifo.sv
// Synchronous FIFO for long-latency results; head is only visible the cycle
// after a push into an empty FIFO. Pointers carry one extra wrap bit.
module fpr_wb_fifo
    import cpu_params_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  fpr_wb_ent_t wr_ent_i,
    output fpr_wb_ent_t head_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push, do_pop;
    fpr_wb_ent_t   mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[IW-1:0]];

    // Guarded handshake and pointer advance.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
    end

    // Pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IW-1:0]] <= wr_ent_i;
        end
    end

endmodule

// File: rtl/fpr_wb.sv
// FP write-back stage: merges pipeline results (priority) and buffered
// long-latency results onto the FBUS write port, and tracks outstanding
// long-latency destinations for decode hazard stalls.
// Build option: FPR_WB_FFLAGS_EN adds pipe/lat fflags inputs, fflags_clr and
// the sticky fflags_acc output.
module fpr_wb
    import cpu_params_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               pipe_wr,
    input  logic [FPR_AW-1:0]  pipe_Fd_addr,
    input  logic [FLEN-1:0]    pipe_Fd_data,
    input  logic               lat_issue,
    input  logic [FPR_AW-1:0]  lat_issue_Fd,
    input  logic               lat_valid,
    output logic               lat_ready,
    input  logic [FPR_AW-1:0]  lat_Fd_addr,
    input  logic [FLEN-1:0]    lat_Fd_data,
`ifdef FPR_WB_FFLAGS_EN
    input  logic [4:0]         lat_fflags,
    input  logic [4:0]         pipe_fflags,
    input  logic               fflags_clr,
    output logic [4:0]         fflags_acc,
`endif
    output logic [MAX_FPR-1:0] fpr_pend,
    FBUS_intf.master           fpr_bus
);
    logic               wr_q, wr_d;
    logic [FPR_AW-1:0]  addr_q, addr_d;
    logic [FLEN-1:0]    data_q, data_d;
    logic [MAX_FPR-1:0] pend_q, pend_d;
    logic               pop, full, empty;
    fpr_wb_ent_t        push_ent, head;
`ifdef FPR_WB_FFLAGS_EN
    logic [4:0]         acc_q, acc_d, new_flags;
`endif

    always_comb begin
        push_ent.addr = lat_Fd_addr;
        push_ent.data = lat_Fd_data;
`ifdef FPR_WB_FFLAGS_EN
        push_ent.fflags = lat_fflags;
`endif
    end

    fpr_wb_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk_i    (clk_in),
        .rst_i    (reset_in),
        .push_i   (lat_valid),
        .pop_i    (pop),
        .wr_ent_i (push_ent),
        .head_o   (head),
        .full_o   (full),
        .empty_o  (empty)
    );

    assign lat_ready       = !full;
    assign fpr_pend        = pend_q;
    assign fpr_bus.Fd_wr   = wr_q;
    assign fpr_bus.Fd_addr = addr_q;
    assign fpr_bus.Fd_data = data_q;
`ifdef FPR_WB_FFLAGS_EN
    assign fflags_acc      = acc_q;
`endif

    // Arbitration (pipeline first), scoreboard update (set beats clear).
    always_comb begin
        wr_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        pop    = 1'b0;
        pend_d = pend_q;
`ifdef FPR_WB_FFLAGS_EN
        new_flags = 5'd0;
`endif
        if (pipe_wr) begin
            wr_d   = 1'b1;
            addr_d = pipe_Fd_addr;
            data_d = pipe_Fd_data;
`ifdef FPR_WB_FFLAGS_EN
            new_flags = pipe_fflags;
`endif
        end else if (!empty) begin
            pop    = 1'b1;
            wr_d   = 1'b1;
            addr_d = head.addr;
            data_d = head.data;
            pend_d[head.addr] = 1'b0;
`ifdef FPR_WB_FFLAGS_EN
            new_flags = head.fflags;
`endif
        end
        if (lat_issue) begin
            pend_d[lat_issue_Fd] = 1'b1;
        end
`ifdef FPR_WB_FFLAGS_EN
        acc_d = (fflags_clr ? 5'd0 : acc_q) | new_flags;
`endif
    end

    // Registered write port and scoreboard.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            pend_q <= '0;
`ifdef FPR_WB_FFLAGS_EN
            acc_q  <= 5'd0;
`endif
        end else begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
            pend_q <= pend_d;
`ifdef FPR_WB_FFLAGS_EN
            acc_q  <= acc_d;
`endif
        end
    end

    // Decode must not issue to a register still pending, unless it retires now.
    a_no_double_issue: assert property (@(posedge clk_in) disable iff (reset_in)
        lat_issue |-> (!pend_q[lat_issue_Fd] || (pop && head.addr == lat_issue_Fd)));

endmodule

// File: tb/tb_fpr_wb.sv
// Scoreboard bench for fpr_wb: a queue-level model predicts each write and
// the lat_ready / fpr_pend / fflags_acc state; a monitor checks the bus.
module tb_fpr_wb;
    import cpu_params_pkg::*;

    localparam int unsigned QDEPTH = 4;

    typedef struct { logic [4:0] a; logic [31:0] d; logic [4:0] f; } ent_t;
    typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_in = 1'b1;
    logic        pipe_wr = 1'b0, lat_issue = 1'b0, lat_valid = 1'b0, fflags_clr = 1'b0;
    logic [4:0]  pipe_Fd_addr = '0, lat_issue_Fd = '0, lat_Fd_addr = '0;
    logic [31:0] pipe_Fd_data = '0, lat_Fd_data = '0;
    logic [4:0]  lat_fflags = '0, pipe_fflags = '0;
    logic        lat_ready;
    logic [31:0] fpr_pend;
    logic [4:0]  fflags_acc;

    FBUS_intf bus ();

    fpr_wb #(.QDEPTH(QDEPTH)) dut (
        .clk_in       (clk),
        .reset_in     (reset_in),
        .pipe_wr      (pipe_wr),
        .pipe_Fd_addr (pipe_Fd_addr),
        .pipe_Fd_data (pipe_Fd_data),
        .lat_issue    (lat_issue),
        .lat_issue_Fd (lat_issue_Fd),
        .lat_valid    (lat_valid),
        .lat_ready    (lat_ready),
        .lat_Fd_addr  (lat_Fd_addr),
        .lat_Fd_data  (lat_Fd_data),
`ifdef FPR_WB_FFLAGS_EN
        .lat_fflags   (lat_fflags),
        .pipe_fflags  (pipe_fflags),
        .fflags_clr   (fflags_clr),
        .fflags_acc   (fflags_acc),
`endif
        .fpr_pend     (fpr_pend),
        .fpr_bus      (bus.master)
    );

    int passed = 0, total = 0, cyc = 0;
    bit mon_en = 1'b0;

    // Reference state.
    ent_t        mq[$];
    exp_t        sb[$];
    logic [31:0] mpend = '0;
    logic [4:0]  macc = '0;
    logic [4:0]  inflight[$];

    // Stimulus for the next cycle.
    logic        s_rst, s_pw, s_li, s_lv, s_clr;
    logic [4:0]  s_pa, s_lif, s_la, s_pf, s_lf;
    logic [31:0] s_pd, s_ld;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clr_stim();
        s_rst = 0; s_pw = 0; s_li = 0; s_lv = 0; s_clr = 0;
        s_pa = 0; s_lif = 0; s_la = 0; s_pf = 0; s_lf = 0; s_pd = 0; s_ld = 0;
    endtask

    // Apply one cycle of stimulus, advance the model, then check state.
    task automatic step();
        ent_t e;
        exp_t x;
        logic [4:0] nf;
        logic ready;
        reset_in = s_rst; pipe_wr = s_pw; pipe_Fd_addr = s_pa; pipe_Fd_data = s_pd;
        pipe_fflags = s_pf; lat_issue = s_li; lat_issue_Fd = s_lif; lat_valid = s_lv;
        lat_Fd_addr = s_la; lat_Fd_data = s_ld; lat_fflags = s_lf; fflags_clr = s_clr;
        ready = (mq.size() < QDEPTH);
        if (s_rst) begin
            mq.delete(); mpend = '0; macc = '0;
        end else begin
            nf = 5'd0;
            if (s_pw) begin
                x.cyc = cyc + 1; x.a = s_pa; x.d = s_pd; sb.push_back(x); nf = s_pf;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                x.cyc = cyc + 1; x.a = e.a; x.d = e.d; sb.push_back(x);
                mpend[e.a] = 1'b0; nf = e.f;
            end
            if (s_li) mpend[s_lif] = 1'b1;
            if (s_lv && ready) begin
                e.a = s_la; e.d = s_ld; e.f = s_lf; mq.push_back(e);
            end
            macc = (s_clr ? 5'd0 : macc) | nf;
        end
        @(negedge clk);
        chk("lat_ready", 64'(lat_ready), 64'(mq.size() < QDEPTH));
        chk("fpr_pend", 64'(fpr_pend), 64'(mpend));
`ifdef FPR_WB_FFLAGS_EN
        chk("fflags_acc", 64'(fflags_acc), 64'(macc));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin clr_stim(); step(); end
    endtask

    // Monitor: every bus write must match the oldest prediction, on time.
    always @(negedge clk) begin : monitor
        exp_t x;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                x = sb.pop_front();
                total++;
                $display("FAIL wb_late: no write seen, expected addr %0d data %h in cycle %0d", x.a, x.d, x.cyc);
            end
            if (bus.Fd_wr === 1'b1) begin
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    x = sb.pop_front();
                    chk("wb_addr", 64'(bus.Fd_addr), 64'(x.a));
                    chk("wb_data", 64'(bus.Fd_data), 64'(x.d));
                end else begin
                    total++;
                    $display("FAIL wb_spurious: got write addr %0d data %h, expected none (cycle %0d)",
                             bus.Fd_addr, bus.Fd_data, cyc);
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                x = sb.pop_front();
                total++;
                $display("FAIL wb_missing: got Fd_wr=%b, expected write addr %0d data %h (cycle %0d)",
                         bus.Fd_wr, x.a, x.d, cyc);
            end
        end
    end

    initial begin
        clr_stim(); s_rst = 1; step(); step();
        mon_en = 1'b1;
        chk("rst_Fd_wr", 64'(bus.Fd_wr), 64'd0);
        chk("rst_Fd_addr", 64'(bus.Fd_addr), 64'd0);
        chk("rst_Fd_data", 64'(bus.Fd_data), 64'd0);
        idle(1);

        // Single pipeline write.
        clr_stim(); s_pw = 1; s_pa = 3; s_pd = 32'h3F800000; s_pf = 5'h01; step();
        idle(2);

        // Long-latency op to F5.
        clr_stim(); s_li = 1; s_lif = 5; step();
        idle(2);
        clr_stim(); s_lv = 1; s_la = 5; s_ld = 32'h40490FDB; s_lf = 5'h08; step();
        idle(3);

        // Fill under continuous pipeline traffic, try a push while full, then drain.
        for (int i = 0; i < 5; i++) begin
            clr_stim(); s_pw = 1; s_pa = 5'(i + 10); s_pd = $urandom;
            s_lv = 1; s_la = 5'(i + 20); s_ld = 32'hA000_0000 + 32'(i); step();
        end
        clr_stim(); s_clr = 1; s_pw = 1; s_pa = 1; s_pd = 32'h1234_5678; s_pf = 5'h02; step();
        idle(6);

        // Re-issue to F7 in the cycle its pending result retires.
        clr_stim(); s_li = 1; s_lif = 7; step();
        clr_stim(); s_lv = 1; s_la = 7; s_ld = 32'h7777_0001; step();
        clr_stim(); s_li = 1; s_lif = 7; step();
        clr_stim(); s_lv = 1; s_la = 7; s_ld = 32'h7777_0002; step();
        idle(3);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            clr_stim(); s_pw = 1; s_pa = 5'(i); s_pd = $urandom;
            s_li = 1; s_lif = 5'(i + 12); s_lv = 1; s_la = 5'(i + 12); s_ld = $urandom; step();
        end
        clr_stim(); s_rst = 1; step();
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            clr_stim();
            s_pw = ($urandom_range(0, 99) < 45);
            s_pa = 5'($urandom); s_pd = $urandom; s_pf = 5'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                s_lif = 5'($urandom);
                if (!mpend[s_lif] && inflight.size() < 6) s_li = 1;
            end
            if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
                s_lv = 1; s_la = inflight[0]; s_ld = $urandom; s_lf = 5'($urandom);
                if (mq.size() < QDEPTH) void'(inflight.pop_front());
            end
            s_clr = ($urandom_range(0, 15) == 0);
            step();
            if (s_li) inflight.push_back(s_lif);
        end
        while (inflight.size() > 0) begin
            clr_stim(); s_lv = 1; s_la = inflight[0]; s_ld = $urandom; s_lf = 5'($urandom);
            if (mq.size() < QDEPTH) void'(inflight.pop_front());
            step();
        end
        idle(8);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
